// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write port, issue/flush controls and busy status.
// The consumer's AW is derived from NREGS the same way, so the widths agree by construction.
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write scoreboard, write-to-read bypass
// and optional registered read data. x0 and out-of-range addresses read as zero, never busy.
module regfile_sb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned NRD       = 2,
    parameter int unsigned SYNC_READ = 0
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic                wr_ok;
    logic                iss_ok;
    logic [AW-1:0]       ra [NRD];
    logic [NRD*XLEN-1:0] eff_data;
    logic [NRD-1:0]      eff_busy;

    // Address names a real, writable register (not x0, not beyond NREGS).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    assign wr_ok  = bus.wr_en && addr_ok(bus.wr_addr);
    assign iss_ok = bus.iss_en && addr_ok(bus.iss_addr);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Issue after writeback so a same-edge issue wins; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        eff_data = '0;
        eff_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra[i] = bus.rd_addr[i*AW +: AW];
            if (addr_ok(ra[i])) begin
                if (wr_ok && (bus.wr_addr == ra[i])) begin
                    eff_data[i*XLEN +: XLEN] = bus.wr_data;
                end else begin
                    eff_data[i*XLEN +: XLEN] = regs_q[ra[i]];
                    eff_busy[i]              = busy_q[ra[i]];
                end
            end
        end
    end

    if (SYNC_READ != 0) begin : g_sync_read
        logic [NRD*XLEN-1:0] rd_data_q;
        logic [NRD*XLEN-1:0] rd_data_d;

        assign rd_data_d = eff_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign bus.rd_data = rd_data_q;
    end else begin : g_comb_read
        assign bus.rd_data = eff_data;
    end

    assign bus.rd_busy  = eff_busy;
    assign bus.busy_any = |busy_q;
endmodule
